// File: rtl/serial_monitor.sv
// Host command monitor: FLUSH/header echo/DECODE, then LOAD, DUMP, FILL or EXEC.
// FIFO handshakes pause 1 cycle after each strobe; SERIAL_MONITOR_CHECKSUM_EN appends a data checksum byte.
module serial_monitor #(
  parameter int ADDR_WIDTH = 18,
  parameter int ADDR_BYTES = 3,
  parameter int LEN_BYTES  = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_read,
  output logic [7:0]            tx_data,
  output logic                  tx_write,
  input  logic                  tx_full,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_write,
  input  logic [7:0]            mem_rdata,
  output logic [ADDR_WIDTH-1:0] cpu_start_addr,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic                  running
);

  localparam int AW = ADDR_WIDTH;
  localparam int LW = 8 * LEN_BYTES;
  localparam int HB = 1 + ADDR_BYTES + LEN_BYTES;
  localparam int IW = $clog2(HB + 1);

  typedef enum logic [3:0] {
    S_FLUSH, S_HDR, S_ECHO, S_DECODE, S_NAK,
    S_LOAD_RX, S_LOAD_TX, S_DUMP, S_DUMP_TX,
    S_FILL_RX, S_FILL_TX, S_FILL_WR, S_CSUM, S_EXEC, S_RUN
  } state_t;

`ifdef SERIAL_MONITOR_CHECKSUM_EN
  localparam state_t DONE_ST = S_CSUM;
`else
  localparam state_t DONE_ST = S_HDR;
`endif

  state_t          state, state_n;
  logic            pace;
  logic [IW-1:0]   idx, idx_n;
  logic [2:0]      cmd, cmd_n;
  logic [AW-1:0]   addr, addr_n;
  logic [LW-1:0]   len, len_n;
  logic [7:0]      dbyte, dbyte_n;
  logic [7:0]      csum, csum_n;
  logic [AW-1:0]   start_addr, start_addr_n;
  logic            rx_ok, tx_ok;

  // pace blanks the FIFO flags for the cycle after any pop/push
  assign rx_ok = rx_valid && !pace;
  assign tx_ok = !tx_full && !pace;

  assign mem_addr       = addr;
  assign cpu_start_addr = start_addr;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= S_FLUSH;
      pace       <= 1'b0;
      idx        <= '0;
      cmd        <= '0;
      addr       <= '0;
      len        <= '0;
      dbyte      <= '0;
      csum       <= '0;
      start_addr <= '0;
    end else begin
      state      <= state_n;
      pace       <= rx_read | tx_write;
      idx        <= idx_n;
      cmd        <= cmd_n;
      addr       <= addr_n;
      len        <= len_n;
      dbyte      <= dbyte_n;
      csum       <= csum_n;
      start_addr <= start_addr_n;
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cmd_n        = cmd;
    addr_n       = addr;
    len_n        = len;
    dbyte_n      = dbyte;
    csum_n       = csum;
    start_addr_n = start_addr;
    rx_read      = 1'b0;
    tx_write     = 1'b0;
    tx_data      = dbyte;
    mem_write    = 1'b0;
    mem_wdata    = dbyte;
    cpu_reset    = 1'b0;
    cpu_halt     = 1'b1;
    running      = 1'b0;

    if (reset) begin
      case (state)
        S_FLUSH: begin
          if (!pace) begin
            if (rx_valid) begin
              rx_read = 1'b1;
            end else begin
              idx_n   = '0;
              state_n = S_HDR;
            end
          end
        end
        S_HDR: begin
          if (rx_ok) begin
            rx_read = 1'b1;
            dbyte_n = rx_data;
            // Shift big-endian fields in; the cast drops surplus MSBs
            if (idx == '0)
              cmd_n = rx_data[2:0];
            else if (idx <= IW'(ADDR_BYTES))
              addr_n = AW'({addr, rx_data});
            else
              len_n = LW'({len, rx_data});
            state_n = S_ECHO;
          end
        end
        S_ECHO: begin
          if (tx_ok) begin
            tx_write = 1'b1;
            if (idx == IW'(HB - 1)) begin
              idx_n   = '0;
              state_n = S_DECODE;
            end else begin
              idx_n   = idx + IW'(1);
              state_n = S_HDR;
            end
          end
        end
        S_DECODE: begin
          csum_n = '0;
          case (cmd)
            3'd1:    state_n = S_LOAD_RX;
            3'd2:    state_n = S_DUMP;
            3'd3: begin
              start_addr_n = addr;
              state_n      = S_EXEC;
            end
            3'd4:    state_n = S_FILL_RX;
            default: state_n = S_NAK;
          endcase
        end
        S_NAK: begin
          if (tx_ok) begin
            tx_write = 1'b1;
            tx_data  = 8'h15;
            state_n  = S_HDR;
          end
        end
        S_LOAD_RX: begin
          if (len == '0) begin
            state_n = DONE_ST;
          end else if (rx_ok) begin
            rx_read   = 1'b1;
            dbyte_n   = rx_data;
            mem_write = 1'b1;
            mem_wdata = rx_data;
            state_n   = S_LOAD_TX;
          end
        end
        S_LOAD_TX: begin
          if (tx_ok) begin
            tx_write = 1'b1;
            csum_n   = csum + dbyte;
            addr_n   = addr + AW'(1);
            len_n    = len - LW'(1);
            state_n  = S_LOAD_RX;
          end
        end
        // addr is held a full cycle in S_DUMP so mem_rdata is valid in S_DUMP_TX
        S_DUMP: begin
          state_n = (len == '0) ? DONE_ST : S_DUMP_TX;
        end
        S_DUMP_TX: begin
          if (tx_ok) begin
            tx_write = 1'b1;
            tx_data  = mem_rdata;
            csum_n   = csum + mem_rdata;
            addr_n   = addr + AW'(1);
            len_n    = len - LW'(1);
            state_n  = S_DUMP;
          end
        end
        S_FILL_RX: begin
          if (rx_ok) begin
            rx_read = 1'b1;
            dbyte_n = rx_data;
            state_n = S_FILL_TX;
          end
        end
        S_FILL_TX: begin
          if (tx_ok) begin
            tx_write = 1'b1;
            state_n  = S_FILL_WR;
          end
        end
        S_FILL_WR: begin
          if (len == '0) begin
            state_n = DONE_ST;
          end else begin
            mem_write = 1'b1;
            csum_n    = csum + dbyte;
            addr_n    = addr + AW'(1);
            len_n     = len - LW'(1);
          end
        end
`ifdef SERIAL_MONITOR_CHECKSUM_EN
        S_CSUM: begin
          if (tx_ok) begin
            tx_write = 1'b1;
            tx_data  = csum;
            state_n  = S_HDR;
          end
        end
`endif
        // cpu_halted is not looked at here, only from S_RUN onwards
        S_EXEC: begin
          cpu_reset = 1'b1;
          cpu_halt  = 1'b0;
          running   = 1'b1;
          state_n   = S_RUN;
        end
        S_RUN: begin
          cpu_halt = 1'b0;
          running  = 1'b1;
          if (cpu_halted) state_n = S_FLUSH;
        end
        default: state_n = S_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_monitor.sv
// Directed bench for serial_monitor: FIFO/RAM models plus hand-computed command responses.
module tb_serial_monitor;

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_read;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        tx_full;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic [17:0] cpu_start_addr;
  logic        cpu_reset;
  logic        cpu_halt;
  logic        cpu_halted;
  logic        running;

  always #5 CLK = ~CLK;

  serial_monitor dut (
    .CLK(CLK), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .cpu_start_addr(cpu_start_addr), .cpu_reset(cpu_reset), .cpu_halt(cpu_halt),
    .cpu_halted(cpu_halted), .running(running)
  );

  logic [7:0] rx_buf [0:1023];
  logic [7:0] tx_buf [0:1023];
  logic [7:0] mem    [0:(1<<18)-1];
  int rx_wr = 0;
  int rx_rd = 0;
  int tx_cnt = 0;
  int wr_cnt = 0;
  int rst_cyc = 0;
  int full_viol = 0;

  assign rx_valid = (rx_rd != rx_wr);
  assign rx_data  = rx_buf[rx_rd];

  always @(posedge CLK) begin
    if (rx_read) rx_rd <= rx_rd + 1;
    if (tx_write) begin
      tx_buf[tx_cnt] <= tx_data;
      tx_cnt <= tx_cnt + 1;
      if (tx_full) full_viol <= full_viol + 1;
    end
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
    if (cpu_reset) rst_cyc <= rst_cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  int base;
  logic [7:0] cmd_q[$];
  logic [7:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_cmd();
    foreach (cmd_q[i]) begin
      rx_buf[rx_wr] = cmd_q[i];
      rx_wr = rx_wr + 1;
    end
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (tx_cnt < base + n && t < 3000) begin
      @(negedge CLK);
      t++;
    end
  endtask

  // Waits for exp_q to drain out of TX, then checks count and every byte
  task automatic run_cmp(input string tag);
    int n = exp_q.size();
    wait_tx(n);
    repeat (8) @(negedge CLK);
    check_val({tag, "_cnt"}, tx_cnt - base, n);
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s_b%0d", tag, i), tx_buf[base + i], exp_q[i]);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_rx_read"}, rx_read, 1'b0);
    check_val({tag, "_tx_write"}, tx_write, 1'b0);
    check_val({tag, "_mem_write"}, mem_write, 1'b0);
    check_val({tag, "_cpu_reset"}, cpu_reset, 1'b0);
    check_val({tag, "_cpu_halt"}, cpu_halt, 1'b1);
    check_val({tag, "_running"}, running, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, t;
    reset = 1'b0;
    tx_full = 1'b0;
    cpu_halted = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle("reset");
    check_val("reset_mem_addr", mem_addr, 18'h0);
    check_val("reset_start", cpu_start_addr, 18'h0);
    reset = 1'b1;
    repeat (3) @(negedge CLK);

    // LOAD 3 bytes at 0x10
    base = tx_cnt; w0 = wr_cnt;
    cmd_q = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    exp_q = cmd_q;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    exp_q.push_back(8'h31);
`endif
    push_cmd();
    run_cmp("load");
    check_val("load_m10", mem[18'h10], 8'hAA);
    check_val("load_m11", mem[18'h11], 8'hBB);
    check_val("load_m12", mem[18'h12], 8'hCC);
    check_val("load_writes", wr_cnt - w0, 3);

    // DUMP them back
    base = tx_cnt;
    cmd_q = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h00, 8'h03};
    exp_q = cmd_q;
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    exp_q.push_back(8'h31);
`endif
    push_cmd();
    run_cmp("dump");

    // FILL across the top of the address space
    base = tx_cnt; w0 = wr_cnt;
    cmd_q = '{8'h04, 8'h03, 8'hFF, 8'hFE, 8'h00, 8'h04, 8'h5A};
    exp_q = cmd_q;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    exp_q.push_back(8'h68);
`endif
    push_cmd();
    run_cmp("fill");
    check_val("fill_3fffe", mem[18'h3FFFE], 8'h5A);
    check_val("fill_3ffff", mem[18'h3FFFF], 8'h5A);
    check_val("fill_00000", mem[18'h00000], 8'h5A);
    check_val("fill_00001", mem[18'h00001], 8'h5A);
    check_val("fill_writes", wr_cnt - w0, 4);
    check_val("fill_addr_end", mem_addr, 18'h00002);

    // Unknown command gets NAK, next header parses normally
    base = tx_cnt;
    cmd_q = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_q = cmd_q;
    exp_q.push_back(8'h15);
    push_cmd();
    run_cmp("nak");
    base = tx_cnt;
    cmd_q = '{8'h02, 8'h00, 8'h00, 8'h11, 8'h00, 8'h01};
    exp_q = cmd_q;
    exp_q.push_back(8'hBB);
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    exp_q.push_back(8'hBB);
`endif
    push_cmd();
    run_cmp("after_nak");

    // Zero-length DUMP transfers nothing
    base = tx_cnt;
    cmd_q = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    exp_q = cmd_q;
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    push_cmd();
    run_cmp("dump_len0");

    // EXEC: cpu_halted raised in the cpu_reset cycle must be ignored
    base = tx_cnt; r0 = rst_cyc;
    cmd_q = '{8'h03, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    exp_q = cmd_q;
    push_cmd();
    t = 0;
    while (cpu_reset !== 1'b1 && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    check_val("exec_cpu_reset", cpu_reset, 1'b1);
    cpu_halted = 1'b1;
    check_val("exec_start", cpu_start_addr, 18'h02000);
    check_val("exec_halt", cpu_halt, 1'b0);
    check_val("exec_running", running, 1'b1);
    @(negedge CLK);
    cpu_halted = 1'b0;
    rx_buf[rx_wr] = 8'h99;
    rx_wr = rx_wr + 1;
    r0 = rx_rd;
    repeat (10) @(negedge CLK);
    check_val("run_running", running, 1'b1);
    check_val("run_halt", cpu_halt, 1'b0);
    check_val("run_no_pop", rx_rd - r0, 0);
    check_val("run_reset_cycles", rst_cyc, 1);
    check_val("exec_echo_cnt", tx_cnt - base, 6);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("exec_b%0d", i), tx_buf[base + i], exp_q[i]);
    cpu_halted = 1'b1;
    @(negedge CLK);
    cpu_halted = 1'b0;
    check_val("halt_running", running, 1'b0);
    check_val("halt_cpu_halt", cpu_halt, 1'b1);
    repeat (6) @(negedge CLK);
    check_val("halt_flushed", rx_wr - rx_rd, 0);

    // Reset in the middle of a LOAD
    base = tx_cnt; w0 = wr_cnt;
    cmd_q = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h05, 8'h11, 8'h22};
    exp_q = cmd_q;
    push_cmd();
    wait_tx(8);
    check_val("midload_cnt", tx_cnt - base, 8);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    check_idle("midload_rst");
    check_val("midload_rst_addr", mem_addr, 18'h0);
    check_val("midload_m100", mem[18'h100], 8'h11);
    check_val("midload_m101", mem[18'h101], 8'h22);
    check_val("midload_writes", wr_cnt - w0, 2);
    reset = 1'b1;
    repeat (3) @(negedge CLK);

    // DUMP stalled by tx_full, then reset
    base = tx_cnt;
    cmd_q = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02};
    push_cmd();
    wait_tx(6);
    tx_full = 1'b1;
    repeat (20) @(negedge CLK);
    check_val("stall_cnt", tx_cnt - base, 6);
    check_val("stall_addr", mem_addr, 18'h00100);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    check_idle("stall_rst");
    reset = 1'b1;
    tx_full = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("stall_after_rst_cnt", tx_cnt - base, 6);

    base = tx_cnt;
    exp_q = cmd_q;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
`ifdef SERIAL_MONITOR_CHECKSUM_EN
    exp_q.push_back(8'h33);
`endif
    push_cmd();
    run_cmp("redump");

    check_val("tx_while_full", full_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
